rvfpm_result_checker: RTL and testbench

Synthesizable, parametrised result checker for the rvfpm FPU, instantiated beside the DUT in the testbench and, optionally, in emulation. It decodes each issued instruction, computes a reference result from the register-file snapshot at issue, and carries it through a delay line of matching pipeline depth. At retirement it compares the reference against the DUT's register file or integer-writeback value and keeps saturating error and check counters plus a sticky first-error record.

---
 rtl/rvfpm_result_checker.sv | 145 ++++++++++++++
 tb/tb_rvfpm_result_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_result_checker.sv
// rvfpm_result_checker: reference model and retirement checker for the rvfpm FPU.
// Decodes each issued instruction, computes the expected result from the
// register-file snapshot at issue, delays it by the DUT pipeline depth and
// compares at retirement. Keeps saturating counters and a sticky first-error record.
module rvfpm_result_checker #(
  parameter int NUM_F_REGS      = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [31:0]             instruction,
  input  logic [31:0]             data_fromXReg,
  input  logic [31:0]             data_toXReg,
  input  logic [NUM_F_REGS*32-1:0] registerFile,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        chk_cnt,
  output logic                    err_pulse,
  output logic                    first_err_valid,
  output logic [3:0]              first_err_op,
  output logic [4:0]              first_err_rd,
  output logic [31:0]             first_err_exp,
  output logic [31:0]             first_err_act
);
  localparam int LAT = PIPELINE_STAGES + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic        vld;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] exp;
  } ent_t;

  // Unpacked view of the flattened register file
  logic [31:0] rf_w [NUM_F_REGS];
  for (genvar i = 0; i < NUM_F_REGS; i++) begin : g_rf
    assign rf_w[i] = registerFile[32*i +: 32];
  end

  ent_t [LAT-1:0] line_q;
  ent_t           ent_d;
  logic [31:0]    a, b;
  logic           a_nan, b_nan, a_lt_b;

  // Issue-side decode and reference computation
  always_comb begin
    a      = rf_w[instruction[19:15]];
    b      = rf_w[instruction[24:20]];
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    // Sign-magnitude ordering; differing signs put -0 below +0
    if (a[31] != b[31])  a_lt_b = a[31];
    else if (!a[31])     a_lt_b = (a[30:0] < b[30:0]);
    else                 a_lt_b = (a[30:0] > b[30:0]);
    ent_d     = '0;
    ent_d.vld = 1'b1;
    ent_d.rd  = instruction[11:7];
    if (instruction[6:0] == 7'b1010011) begin
      case ({instruction[31:25], instruction[14:12]})
        10'b0010000_000: begin ent_d.op = 4'd1; ent_d.exp = {b[31], a[30:0]}; end
        10'b0010000_001: begin ent_d.op = 4'd2; ent_d.exp = {~b[31], a[30:0]}; end
        10'b0010000_010: begin ent_d.op = 4'd3; ent_d.exp = {a[31] ^ b[31], a[30:0]}; end
        10'b0010100_000: if (!a_nan && !b_nan) begin
          ent_d.op = 4'd4; ent_d.exp = a_lt_b ? a : b;
        end
        10'b0010100_001: if (!a_nan && !b_nan) begin
          ent_d.op = 4'd5; ent_d.exp = a_lt_b ? b : a;
        end
        10'b1110000_000: begin ent_d.op = 4'd6; ent_d.exp = a; end
        10'b1110000_001: ent_d.op = 4'd7;
        10'b1111000_000: begin ent_d.op = 4'd8; ent_d.exp = data_fromXReg; end
        default: ent_d.op = 4'd0;
      endcase
    end
  end

  ent_t        tail;
  logic [31:0] act;
  logic        do_chk, fail;

  // Retirement-side comparison against pre-edge DUT state
  always_comb begin
    tail   = line_q[LAT-1];
    act    = (tail.op == 4'd6 || tail.op == 4'd7) ? data_toXReg : rf_w[tail.rd];
    do_chk = enable && tail.vld && (tail.op != 4'd0);
    if (tail.op == 4'd7) fail = $isunknown(act) || ($countones(act) != 1);
    else                 fail = (act !== tail.exp);
  end

  // Delay line: shifts only on enable edges
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (enable) begin
      for (int i = LAT-1; i > 0; i--) line_q[i] <= line_q[i-1];
      line_q[0] <= ent_d;
    end
  end

  logic [CNT_W-1:0] err_cnt_q, chk_cnt_q;
  logic             err_pulse_q, fe_vld_q;
  logic [3:0]       fe_op_q;
  logic [4:0]       fe_rd_q;
  logic [31:0]      fe_exp_q, fe_act_q;

  // Saturating counters, registered error pulse and sticky first-error record
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      err_cnt_q   <= '0;
      chk_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      fe_vld_q    <= 1'b0;
      fe_op_q     <= '0;
      fe_rd_q     <= '0;
      fe_exp_q    <= '0;
      fe_act_q    <= '0;
    end else begin
      err_pulse_q <= do_chk && fail;
      if (do_chk) begin
        if (chk_cnt_q != '1) chk_cnt_q <= chk_cnt_q + CNT_ONE;
        if (fail) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
          if (!fe_vld_q) begin
            fe_vld_q <= 1'b1;
            fe_op_q  <= tail.op;
            fe_rd_q  <= tail.rd;
            fe_exp_q <= tail.exp;
            fe_act_q <= act;
          end
        end
      end
    end
  end

  assign err_cnt         = err_cnt_q;
  assign chk_cnt         = chk_cnt_q;
  assign err_pulse       = err_pulse_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_op    = fe_op_q;
  assign first_err_rd    = fe_rd_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_act   = fe_act_q;
endmodule

// File: tb/tb_rvfpm_result_checker.sv
// Scoreboard bench for rvfpm_result_checker: directed vectors push hand-computed
// expectations; a monitor pops one entry each time the checker performs a check.
module tb_rvfpm_result_checker;
  localparam int LAT = 5;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [31:0]   instruction = '0;
  logic [31:0]   data_fromXReg = '0;
  logic [31:0]   data_toXReg = '0;
  logic [31:0]   rf [32];
  logic [1023:0] registerFile;

  logic [15:0] err_cnt, chk_cnt;
  logic        err_pulse, first_err_valid;
  logic [3:0]  first_err_op;
  logic [4:0]  first_err_rd;
  logic [31:0] first_err_exp, first_err_act;

  logic [3:0]  b_err_cnt, b_chk_cnt;
  logic        b_err_pulse, b_fe_valid;
  logic [3:0]  b_fe_op;
  logic [4:0]  b_fe_rd;
  logic [31:0] b_fe_exp, b_fe_act;

  for (genvar i = 0; i < 32; i++) begin : g_rf
    assign registerFile[32*i +: 32] = rf[i];
  end

  always #5 ck = ~ck;

  rvfpm_result_checker #(.NUM_F_REGS(32), .PIPELINE_STAGES(4), .CNT_W(16)) dut (
    .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
    .data_fromXReg(data_fromXReg), .data_toXReg(data_toXReg), .registerFile(registerFile),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .err_pulse(err_pulse),
    .first_err_valid(first_err_valid), .first_err_op(first_err_op), .first_err_rd(first_err_rd),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act));

  rvfpm_result_checker #(.NUM_F_REGS(32), .PIPELINE_STAGES(4), .CNT_W(4)) dut_sat (
    .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
    .data_fromXReg(data_fromXReg), .data_toXReg(data_toXReg), .registerFile(registerFile),
    .err_cnt(b_err_cnt), .chk_cnt(b_chk_cnt), .err_pulse(b_err_pulse),
    .first_err_valid(b_fe_valid), .first_err_op(b_fe_op), .first_err_rd(b_fe_rd),
    .first_err_exp(b_fe_exp), .first_err_act(b_fe_act));

  typedef struct {
    logic        fail;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic [31:0] act;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b1010011};
  endfunction

  task automatic push(input logic f, input logic [3:0] op, input logic [4:0] rd,
                      input logic [31:0] e, input logic [31:0] a);
    exp_t x;
    x.fail = f; x.op = op; x.rd = rd; x.exp = e; x.act = a;
    q.push_back(x);
  endtask

  // One enable edge carrying an instruction; inputs change on the falling edge
  task automatic go(input logic [31:0] ins, input logic [31:0] xin);
    enable = 1'b1; instruction = ins; data_fromXReg = xin;
    @(posedge ck); @(negedge ck);
    instruction = '0;
  endtask

  task automatic idle(input int n, input logic en);
    enable = en;
    repeat (n) begin @(posedge ck); @(negedge ck); end
  endtask

  // Issue, run to the retiring edge, present DUT results just before it
  task automatic run1(input logic [31:0] ins, input logic [31:0] xin, input int wr,
                      input logic [31:0] wv, input logic [31:0] tox);
    go(ins, xin);
    idle(LAT-1, 1'b1);
    if (wr >= 0) rf[wr] = wv;
    data_toXReg = tox;
    idle(1, 1'b1);
  endtask

  // Monitor: one scoreboard entry per observed check
  initial begin : monitor
    logic [15:0] m_chk, m_err;
    logic        fe_set;
    exp_t        fe, e;
    m_chk = '0; m_err = '0; fe_set = 1'b0;
    forever begin
      @(posedge ck); #1;
      if (rst) begin
        q.delete(); m_chk = '0; m_err = '0; fe_set = 1'b0;
      end else if (chk_cnt !== m_chk) begin
        if (q.size() == 0) begin
          cmp("unexpected_check", chk_cnt, m_chk);
          m_chk = chk_cnt; m_err = err_cnt;
        end else begin
          e = q.pop_front();
          m_chk = m_chk + 16'd1;
          m_err = m_err + {15'd0, e.fail};
          cmp("chk_cnt", chk_cnt, m_chk);
          cmp("err_cnt", err_cnt, m_err);
          cmp("err_pulse", {31'd0, err_pulse}, {31'd0, e.fail});
          if (e.fail && !fe_set) begin fe = e; fe_set = 1'b1; end
          cmp("first_err_valid", {31'd0, first_err_valid}, {31'd0, fe_set});
          if (fe_set) begin
            cmp("first_err_op", {28'd0, first_err_op}, {28'd0, fe.op});
            cmp("first_err_rd", {27'd0, first_err_rd}, {27'd0, fe.rd});
            cmp("first_err_exp", first_err_exp, fe.exp);
            cmp("first_err_act", first_err_act, fe.act);
          end
        end
      end else begin
        cmp("err_pulse_idle", {31'd0, err_pulse}, 32'd0);
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'h3F800000; rf[2] = 32'hC0000000;
    rf[7] = 32'h80000000; rf[8] = 32'h00000000;
    rf[10] = 32'h7FC00000;
    rf[13] = 32'hC0400000; rf[14] = 32'hC0000000;
    repeat (3) @(negedge ck);
    cmp("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    cmp("rst_chk_cnt", {16'd0, chk_cnt}, 32'd0);
    cmp("rst_fe_valid", {31'd0, first_err_valid}, 32'd0);
    cmp("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    rst = 1'b0;
    idle(2, 1'b1);

    // FSGNJ / FSGNJN / FSGNJX
    push(0, 4'd1, 5'd3, 32'hBF800000, 32'hBF800000);
    run1(enc(7'b0010000, 3'b000, 5'd2, 5'd1, 5'd3), 0, 3, 32'hBF800000, 0);
    push(0, 4'd2, 5'd4, 32'h3F800000, 32'h3F800000);
    run1(enc(7'b0010000, 3'b001, 5'd2, 5'd1, 5'd4), 0, 4, 32'h3F800000, 0);
    push(0, 4'd3, 5'd5, 32'h40000000, 32'h40000000);
    run1(enc(7'b0010000, 3'b010, 5'd2, 5'd2, 5'd5), 0, 5, 32'h40000000, 0);
    // FMIN(-0,+0) must be -0; DUT returns +0 -> first error
    push(1, 4'd4, 5'd6, 32'h80000000, 32'h00000000);
    run1(enc(7'b0010100, 3'b000, 5'd8, 5'd7, 5'd6), 0, 6, 32'h00000000, 0);
    // FMAX with NaN operand: no check
    run1(enc(7'b0010100, 3'b001, 5'd8, 5'd10, 5'd9), 0, 9, 32'h12345678, 0);
    push(0, 4'd5, 5'd11, 32'h3F800000, 32'h3F800000);
    run1(enc(7'b0010100, 3'b001, 5'd2, 5'd1, 5'd11), 0, 11, 32'h3F800000, 0);
    push(0, 4'd4, 5'd12, 32'hC0400000, 32'hC0400000);
    run1(enc(7'b0010100, 3'b000, 5'd14, 5'd13, 5'd12), 0, 12, 32'hC0400000, 0);
    // FMV.X.W and FCLASS
    push(0, 4'd6, 5'd0, 32'h3F800000, 32'h3F800000);
    run1(enc(7'b1110000, 3'b000, 5'd0, 5'd1, 5'd0), 0, -1, 0, 32'h3F800000);
    push(1, 4'd7, 5'd0, 32'h0, 32'h00000060);
    run1(enc(7'b1110000, 3'b001, 5'd0, 5'd1, 5'd0), 0, -1, 0, 32'h00000060);
    push(0, 4'd7, 5'd0, 32'h0, 32'h00000040);
    run1(enc(7'b1110000, 3'b001, 5'd0, 5'd1, 5'd0), 0, -1, 0, 32'h00000040);
    // FMV.W.X with a 3-cycle enable stall mid-flight
    push(0, 4'd8, 5'd15, 32'h12345678, 32'h12345678);
    go(enc(7'b1111000, 3'b000, 5'd0, 5'd0, 5'd15), 32'h12345678);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);
    rf[15] = 32'h12345678;
    idle(1, 1'b1);
    idle(1, 1'b1);
    cmp("pre_rst_chk_cnt", {16'd0, chk_cnt}, 32'd10);
    cmp("pre_rst_err_cnt", {16'd0, err_cnt}, 32'd2);

    // Reset at the third enable edge after issue discards the in-flight op
    go(enc(7'b1111000, 3'b000, 5'd0, 5'd0, 5'd16), 32'hAAAA5555);
    idle(2, 1'b1);
    rst = 1'b1;
    #1;
    cmp("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
    cmp("midrst_fe_valid", {31'd0, first_err_valid}, 32'd0);
    cmp("midrst_fe_exp", first_err_exp, 32'd0);
    idle(1, 1'b1);
    rst = 1'b0;
    idle(6, 1'b1);
    cmp("post_rst_chk_cnt", {16'd0, chk_cnt}, 32'd0);
    cmp("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Back-to-back issue; sixth issue lands on the retire edge of the first (same rd)
    for (int k = 0; k < 5; k++) begin
      push(0, 4'd1, 5'(20 + k), 32'hBF800000, 32'hBF800000);
      go(enc(7'b0010000, 3'b000, 5'd2, 5'd1, 5'(20 + k)), 0);
      rf[20 + k] = 32'hBF800000;
    end
    push(0, 4'd3, 5'd20, 32'h3F800000, 32'h3F800000);
    go(enc(7'b0010000, 3'b010, 5'd20, 5'd20, 5'd20), 0);
    rf[20] = 32'h3F800000;
    idle(LAT, 1'b1);

    // First failure after reset, then 20 back-to-back failures
    push(1, 4'd6, 5'd7, 32'h3F800000, 32'h0);
    run1(enc(7'b1110000, 3'b000, 5'd0, 5'd1, 5'd7), 0, -1, 0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      push(1, 4'd6, 5'd7, 32'h3F800000, 32'h0);
      go(enc(7'b1110000, 3'b000, 5'd0, 5'd1, 5'd7), 0);
    end
    idle(LAT + 1, 1'b1);

    cmp("final_chk_cnt", {16'd0, chk_cnt}, 32'd27);
    cmp("final_err_cnt", {16'd0, err_cnt}, 32'd21);
    cmp("sat_err_cnt", {28'd0, b_err_cnt}, 32'hF);
    cmp("sat_chk_cnt", {28'd0, b_chk_cnt}, 32'hF);
    cmp("sat_fe_valid", {31'd0, b_fe_valid}, 32'd1);
    cmp("sat_fe_op", {28'd0, b_fe_op}, 32'd6);
    cmp("sat_fe_rd", {27'd0, b_fe_rd}, 32'd7);
    cmp("sat_fe_exp", b_fe_exp, 32'h3F800000);
    cmp("sat_fe_act", b_fe_act, 32'h0);
    cmp("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
